sd_spi_card_responder: RTL and testbench

Synthesizable SD-card SPI-mode target (card side) that answers the host initialisation sequence: CMD0, CMD8, CMD55/ACMD41 and CMD16.
It receives 48-bit command frames on MOSI and returns R1 or R7 responses on MISO.
It sits on the SPI pins in place of a physical card, for on-board loopback test of the host init/command logic and for simulation.
It oversamples the SPI signals in the clk domain.

---
 rtl/sd_spi_card_responder_if.sv | 10 +
 rtl/sd_spi_card_responder.sv | 155 +++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sd_spi_card_responder_if.sv
// sd_spi_card_responder_if: SPI pin bundle between an SD host and the card-side responder.
interface sd_spi_card_responder_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;
    modport master (output sclk, cs_n, mosi, input miso, miso_oe);
    modport slave (input sclk, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: SPI-mode SD card model answering CMD0, CMD8, CMD55/ACMD41 and CMD16.
module sd_spi_card_responder #(
    parameter int NCR_BYTES         = 1,
    parameter int ACMD41_BUSY_COUNT = 2,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    sd_spi_card_responder_if.slave    bus,
    output logic                      in_idle,
    output logic                      initialized,
    output logic [31:0]               block_len,
    output logic [5:0]                last_cmd
);
    typedef enum logic [2:0] {HUNT, RECV, CRCCHK, NCR, RESP} state_t;
    localparam logic [7:0] BUSY_INIT = 8'(ACMD41_BUSY_COUNT);
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
        return c;
    endfunction
    logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
    logic sclk_d, sclk_q, cs_q, mosi_q, rise, fall;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s <= '0;
            cs_s   <= '1;
            mosi_s <= '1;
            sclk_d <= 1'b0;
        end else begin
            sclk_s <= SYNC_STAGES'({sclk_s, bus.sclk});
            cs_s   <= SYNC_STAGES'({cs_s, bus.cs_n});
            mosi_s <= SYNC_STAGES'({mosi_s, bus.mosi});
            sclk_d <= sclk_q;
        end
    end
    assign sclk_q = sclk_s[SYNC_STAGES-1];
    assign cs_q   = cs_s[SYNC_STAGES-1];
    assign mosi_q = mosi_s[SYNC_STAGES-1];
    assign rise   = sclk_q & ~sclk_d & ~cs_q;
    assign fall   = ~sclk_q & sclk_d & ~cs_q;
    state_t state;
    logic [47:0] rx;
    logic [39:0] tx;
    logic [6:0] cnt, rlen;
    logic [7:0] busy, n_busy, r1;
    logic app, n_app, n_idle, n_init, framed, crc_ok, e_param, e_crc, e_ill, has_trail;
    logic [5:0] idx;
    logic [31:0] arg, n_blen;
    // Next card state and R1 for the frame held in rx; committed only in CRCCHK.
    always_comb begin
        idx       = rx[45:40];
        arg       = rx[39:8];
        framed    = rx[46];
        crc_ok    = rx[7:0] == {crc7(rx[47:8]), 1'b1};
        n_idle    = in_idle;
        n_init    = initialized;
        n_busy    = busy;
        n_blen    = block_len;
        n_app     = 1'b0;
        e_param   = 1'b0;
        e_crc     = 1'b0;
        e_ill     = 1'b0;
        has_trail = 1'b0;
        case (idx)
            6'd0: begin
                n_idle = crc_ok ? 1'b1 : in_idle;
                n_init = crc_ok ? 1'b0 : initialized;
                n_busy = crc_ok ? BUSY_INIT : busy;
                n_app  = crc_ok ? 1'b0 : app;
                e_crc  = ~crc_ok;
            end
            6'd8: begin
                has_trail = crc_ok;
                e_crc     = ~crc_ok;
            end
            6'd55: n_app = 1'b1;
            6'd41: begin
                e_ill  = ~app;
                n_busy = (app && busy != 8'd0) ? busy - 8'd1 : busy;
                n_idle = (app && busy == 8'd0) ? 1'b0 : in_idle;
                n_init = (app && busy == 8'd0) ? 1'b1 : initialized;
            end
            6'd16: begin
                e_param = (arg == 32'd0) || (arg > 32'd512);
                n_blen  = e_param ? block_len : arg;
            end
            default: e_ill = 1'b1;
        endcase
        r1 = {1'b0, e_param, 2'b00, e_crc, e_ill, 1'b0, n_idle};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            bus.miso    <= 1'b1;
            bus.miso_oe <= 1'b0;
            in_idle     <= 1'b1;
            initialized <= 1'b0;
            block_len   <= 32'd512;
            last_cmd    <= 6'd0;
            app         <= 1'b0;
            busy        <= BUSY_INIT;
            rx          <= '0;
            tx          <= '0;
            cnt         <= '0;
            rlen        <= '0;
        end else begin
            bus.miso_oe <= ~cs_q;
            if (cs_q) begin
                state    <= HUNT;
                bus.miso <= 1'b1;
            end else begin
                case (state)
                    HUNT: if (rise && !mosi_q) begin
                        rx    <= '0;
                        cnt   <= 7'd1;
                        state <= RECV;
                    end
                    RECV: if (rise) begin
                        rx    <= {rx[46:0], mosi_q};
                        cnt   <= cnt + 7'd1;
                        state <= (cnt == 7'd47) ? CRCCHK : RECV;
                    end
                    CRCCHK: begin
                        if (framed) begin
                            last_cmd    <= idx;
                            in_idle     <= n_idle;
                            initialized <= n_init;
                            busy        <= n_busy;
                            block_len   <= n_blen;
                            app         <= n_app;
                            tx          <= {r1, has_trail ? {20'h0, arg[11:0]} : 32'h0};
                            rlen        <= has_trail ? 7'd40 : 7'd8;
                            cnt         <= 7'(NCR_BYTES * 8);
                        end
                        state <= framed ? NCR : HUNT;
                    end
                    NCR: if (fall) begin
                        bus.miso <= 1'b1;
                        cnt      <= (cnt == 7'd1) ? rlen : cnt - 7'd1;
                        state    <= (cnt == 7'd1) ? RESP : NCR;
                    end
                    RESP: if (fall) begin
                        bus.miso <= (cnt == 7'd0) ? 1'b1 : tx[39];
                        tx       <= {tx[38:0], 1'b0};
                        cnt      <= (cnt == 7'd0) ? cnt : cnt - 7'd1;
                        state    <= (cnt == 7'd0) ? HUNT : RESP;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// tb_sd_spi_card_responder: host-side SPI driver with a byte scoreboard on MISO plus direct flag checks.
module tb_sd_spi_card_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    sd_spi_card_responder_if bus();
    logic in_idle, initialized;
    logic [31:0] block_len;
    logic [5:0] last_cmd;
    sd_spi_card_responder #(.NCR_BYTES(1), .ACMD41_BUSY_COUNT(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .in_idle(in_idle), .initialized(initialized), .block_len(block_len), .last_cmd(last_cmd)
    );
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic capture = 1'b0;
    // Monitor: assembles MISO bytes on host sampling edges and scores them against the queue.
    initial begin
        logic [7:0] sh, e;
        int nb;
        nb = 0;
        sh = '0;
        forever begin
            @(posedge bus.sclk);
            if (capture) begin
                sh = {sh[6:0], bus.miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL miso_byte unexpected: got %02h, none expected", sh);
                    end else begin
                        e = exp_q.pop_front();
                        if (sh !== e) begin
                            errors++;
                            $display("FAIL miso_byte got %02h expected %02h", sh, e);
                        end
                    end
                end
            end else nb = 0;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic half();
        repeat (4) @(negedge clk);
    endtask
    task automatic bit_x(input logic b);
        bus.mosi = b;
        half();
        bus.sclk = 1'b1;
        half();
        bus.sclk = 1'b0;
    endtask
    task automatic send(input logic [47:0] f, input int nbits);
        for (int i = 47; i > 47 - nbits; i--) bit_x(f[i]);
    endtask
    // Sends a frame, queues the NCR filler plus n expected bytes, then clocks them back.
    task automatic xact(input logic [47:0] f, input logic [39:0] r, input int n);
        exp_q.push_back(8'hFF);
        for (int k = 0; k < n; k++) exp_q.push_back(r[39-8*k -: 8]);
        send(f, 48);
        capture = 1'b1;
        for (int i = 0; i < (n + 1) * 8; i++) bit_x(1'b1);
        capture = 1'b0;
    endtask
    localparam logic [47:0] CMD0   = 48'h40_00_00_00_00_95;
    localparam logic [47:0] CMD0B  = 48'h40_00_00_00_00_94;
    localparam logic [47:0] CMD8   = 48'h48_00_00_01_AA_87;
    localparam logic [47:0] CMD55  = 48'h77_00_00_00_00_65;
    localparam logic [47:0] ACMD41 = 48'h69_40_00_00_00_77;
    initial begin
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(bus.miso), 32'd1);
        chk("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("rst_in_idle", 32'(in_idle), 32'd1);
        chk("rst_initialized", 32'(initialized), 32'd0);
        chk("rst_block_len", block_len, 32'd512);
        chk("rst_last_cmd", 32'(last_cmd), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("miso_oe_selected", 32'(bus.miso_oe), 32'd1);
        xact(CMD0, {8'h01, 32'h0}, 1);
        chk("cmd0_idle", 32'(in_idle), 32'd1);
        chk("cmd0_last_cmd", 32'(last_cmd), 32'd0);
        xact(CMD0B, {8'h09, 32'h0}, 1);
        chk("cmd0_badcrc_idle", 32'(in_idle), 32'd1);
        chk("cmd0_badcrc_init", 32'(initialized), 32'd0);
        xact(ACMD41, {8'h05, 32'h0}, 1);
        chk("cmd41_noapp_last", 32'(last_cmd), 32'd41);
        xact(CMD8, {8'h01, 32'h0000_01AA}, 5);
        chk("cmd8_last_cmd", 32'(last_cmd), 32'd8);
        for (int i = 0; i < 3; i++) begin
            xact(CMD55, {8'h01, 32'h0}, 1);
            xact(ACMD41, {(i == 2) ? 8'h00 : 8'h01, 32'h0}, 1);
            chk("acmd41_initialized", 32'(initialized), (i == 2) ? 32'd1 : 32'd0);
        end
        chk("init_idle", 32'(in_idle), 32'd0);
        xact(48'h50_00_00_00_04_FF, {8'h00, 32'h0}, 1);
        chk("cmd16_block_len", block_len, 32'd4);
        xact(48'h50_00_00_04_00_FF, {8'h40, 32'h0}, 1);
        chk("cmd16_big_block_len", block_len, 32'd4);
        xact(48'h50_00_00_02_00_FF, {8'h00, 32'h0}, 1);
        chk("cmd16_512_block_len", block_len, 32'd512);
        xact(48'h50_00_00_00_04_FF, {8'h00, 32'h0}, 1);
        xact(ACMD41, {8'h04, 32'h0}, 1);
        xact(48'h51_00_00_00_00_FF, {8'h04, 32'h0}, 1);
        chk("cmd17_last_cmd", 32'(last_cmd), 32'd17);
        xact(48'h00_00_00_00_00_95, {8'hFF, 8'hFF, 24'h0}, 2);
        chk("badframe_last_cmd", 32'(last_cmd), 32'd17);
        send(CMD0, 20);
        bus.mosi = 1'b1;
        half();
        bus.cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("abort_miso", 32'(bus.miso), 32'd1);
        chk("abort_last_cmd", 32'(last_cmd), 32'd17);
        bus.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        xact(CMD8, {8'h00, 32'h0000_01AA}, 5);
        chk("abort_init_kept", 32'(initialized), 32'd1);
        xact(CMD8, {8'h00, 32'h0000_01AA}, 2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midresp_rst_miso", 32'(bus.miso), 32'd1);
        chk("midresp_rst_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("midresp_rst_block_len", block_len, 32'd512);
        chk("midresp_rst_init", 32'(initialized), 32'd0);
        chk("midresp_rst_last_cmd", 32'(last_cmd), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
